shift_add_ctrl: RTL and testbench
=================================

Name: shift_add_ctrl

Overview:
- Control FSM for the 4-bit shift-add multiplier datapath. Sits directly upstream of that datapath.
- Accepts a start request and drives the datapath strobes ld_regs, add_en and shift_en. Reads back the multiplier LSB (q0) every iteration.
- Reports busy, and pulses done when the datapath's product_out is valid.

Parameters:
- WIDTH, 4, multiplier bit count, i.e. number of shift iterations; legal range WIDTH >= 1.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- q0  input  1  current datapath Q[0].
- ld_regs  output  1  load M/Q and clear A in the datapath.
- add_en  output  1  datapath A <= A + M.
- shift_en  output  1  datapath {A,Q} >> 1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product_out is valid during this cycle.

Behaviour:
- Reset: asynchronous and active-low; the block is reset while rst_n is low.
  - Assertion at any time, including mid-multiply, forces IDLE and clears the counter.
  - All outputs are 0 while in reset.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Outputs are Moore (registered-state decode only).
- IDLE: all outputs 0. start=1 -> LOAD; otherwise stay in IDLE.
- LOAD: ld_regs=1, busy=1, counter <= 0 -> TEST.
- TEST: busy=1, no strobes. q0=1 -> ADD; q0=0 -> SHIFT.
- ADD: add_en=1, busy=1 -> SHIFT.
- SHIFT: shift_en=1, busy=1, counter <= counter+1.
  - counter == WIDTH-1 (last shift) -> DONE.
  - Otherwise -> TEST.
- DONE: done=1, busy=1 -> IDLE. A start arriving in this cycle is ignored.
- Strobe exclusivity: add_en and shift_en are never high in the same cycle, because the datapath's shift would discard the add. ld_regs is never high with either of them.
- start while busy: ignored; no queuing. start held high across DONE -> IDLE relaunches a new multiply on the first IDLE cycle.
- Latency, counting start sampled at edge E0:
  - LOAD occupies cycle 1.
  - Each multiplier bit takes 2 cycles (0 bit) or 3 cycles (1 bit).
  - DONE follows the last SHIFT.
  - WIDTH=4 totals range from 10 cycles (multiplier 0) to 14 cycles (multiplier 0xF).
- Counter never exceeds WIDTH-1 and does not wrap. Behaviour for WIDTH=1: single TEST/[ADD]/SHIFT pass.

Optional Feature:
- Macro: SHIFT_ADD_CTRL_FAST_EN.
- Defined: the TEST state is removed and replaced by EVAL, with Mealy strobes decoded from q0:
  - q0=1: add_en=1 -> SHIFT.
  - q0=0: shift_en=1, counter increments, and the state goes to EVAL, or to DONE on the last bit.
  - SHIFT after ADD behaves as above but returns to EVAL.
  - Each bit costs 1 cycle (0 bit) or 2 cycles (1 bit). Strobe exclusivity still holds.
- Undefined: the Moore behaviour above applies; outputs carry no combinational path from q0.

Test Plan:
- Reset: rst_n low mid-ADD -> all outputs 0 immediately (asynchronous); after release, state is IDLE, busy=0.
- Multiplier 0, start pulse -> ld_regs in cycle 1, 4 shift_en pulses, add_en never high, done in cycle 10; then busy=0.
- Multiplier 4'b1011 (q0 sequence 1,1,0,1) -> add_en pulses exactly 3, shift_en pulses 4, done in cycle 13. With multiplicand 4'd5, product_out = 8'd55 in the done cycle.
- start re-asserted in cycles 3 and 12 of an active multiply -> ignored; exactly one done pulse per accepted start.
- start held high continuously -> back-to-back multiplies. Each done is followed by one IDLE cycle, then LOAD.
- SHIFT_ADD_CTRL_FAST_EN with multiplier 4'b1011 -> done in cycle 9. Multiplier 0 -> done in cycle 6. add_en and shift_en are never coincident.

Source files
------------

// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl: control FSM for the WIDTH-bit shift-add multiplier datapath.
// Drives ld_regs / add_en / shift_en, reads back the multiplier LSB (q0) and
// reports busy and a one-cycle done pulse while product_out is valid.
// Optional build macro SHIFT_ADD_CTRL_FAST_EN: replaces the TEST state with
// EVAL, which decodes add/shift strobes from q0 in the same cycle (Mealy).
// The default build is pure Moore, with no combinational path from q0 to any output.
module shift_add_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  output logic ld_regs,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef SHIFT_ADD_CTRL_FAST_EN
  localparam logic [2:0] S_EVAL  = 3'd2;
`else
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
`endif
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // Counter value of the final iteration; the shift issued here is the last one.
  assign last = (cnt == LAST_CNT);

  // State register; reset forces IDLE from anywhere, including mid-multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: cleared on LOAD, advanced on every shift, held on the
  // last shift so it never exceeds WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_LOAD) begin
      cnt <= '0;
    end else if (state == S_SHIFT && !last) begin
      cnt <= cnt + CNT_W'(1);
`ifdef SHIFT_ADD_CTRL_FAST_EN
    end else if (state == S_EVAL && !q0 && !last) begin
      // A 0 multiplier bit shifts straight out of EVAL.
      cnt <= cnt + CNT_W'(1);
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
`ifdef SHIFT_ADD_CTRL_FAST_EN
      S_LOAD:  state_nxt = S_EVAL;
      S_EVAL:  begin
        if (q0)        state_nxt = S_SHIFT;
        else if (last) state_nxt = S_DONE;
        else           state_nxt = S_EVAL;
      end
      S_SHIFT: state_nxt = last ? S_DONE : S_EVAL;
`else
      S_LOAD:  state_nxt = S_TEST;
      S_TEST:  state_nxt = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = last ? S_DONE : S_TEST;
`endif
      // start seen during DONE is dropped; only IDLE accepts a request.
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode. add_en and shift_en come from disjoint states (or disjoint
  // q0 values in EVAL), so the datapath never sees an add lost under a shift.
  always_comb begin
    ld_regs  = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOAD:  ld_regs  = 1'b1;
`ifdef SHIFT_ADD_CTRL_FAST_EN
      S_EVAL:  begin
        add_en   = q0;
        shift_en = ~q0;
      end
`else
      S_ADD:   add_en   = 1'b1;
`endif
      S_SHIFT: shift_en = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl: a behavioural shift-add datapath closes the q0
// loop; results are checked against plain arithmetic (product, cycle counts).
module tb_shift_add_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q0;
  logic ld_regs, add_en, shift_en, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // datapath model
  logic [W-1:0] m_reg, q_reg, a_reg;
  logic         c_reg;
  logic [W-1:0] mcand, mplier;

  always #5 clk = ~clk;

  shift_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0),
    .ld_regs(ld_regs), .add_en(add_en), .shift_en(shift_en),
    .busy(busy), .done(done)
  );

  assign q0 = q_reg[0];

  // Datapath: load clears A, add accumulates with carry, shift moves {C,A,Q} right.
  always @(posedge clk) begin
    if (ld_regs) begin
      m_reg <= mcand; q_reg <= mplier; a_reg <= '0; c_reg <= 1'b0;
    end else if (add_en) begin
      {c_reg, a_reg} <= {1'b0, a_reg} + {1'b0, m_reg};
    end else if (shift_en) begin
      {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg} >> 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [W-1:0] mp);
    int c = 1;
    for (int i = 0; i < W; i++)
`ifdef SHIFT_ADD_CTRL_FAST_EN
      c += mp[i] ? 2 : 1;
`else
      c += mp[i] ? 3 : 2;
`endif
    return c + 1;
  endfunction

  // One multiply from a start pulse; optional stray starts at cycle 3 and in
  // the cycle before done and the done cycle itself, all of which must be ignored.
  task automatic run_mul(input logic [W-1:0] mc, input logic [W-1:0] mp, input bit stray);
    int edone = exp_cycles(mp);
    int n_add = 0, n_sh = 0, n_ld = 0, n_done = 0, n_ovl = 0, done_cyc = -1;
    int prod = -1;
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = stray && (cyc == 3 || cyc == edone - 1 || cyc == edone);
      if (ld_regs) n_ld++;
      if (add_en) n_add++;
      if (shift_en) n_sh++;
      if ((add_en && shift_en) || (ld_regs && (add_en || shift_en))) n_ovl++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        prod = int'({a_reg, q_reg});
      end
      if (cyc == 1) chk("ld_cycle1", int'(ld_regs), 1);
      if (done_cyc > 0 && cyc == done_cyc + 1) break;
      if (done_cyc < 0 && !busy && cyc > 1) break;
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, edone);
    chk("done_count", n_done, 1);
    chk("ld_count", n_ld, 1);
    chk("add_count", n_add, $countones(mp));
    chk("shift_count", n_sh, W);
    chk("strobe_overlap", n_ovl, 0);
    chk("product", prod, int'(mc) * int'(mp));
    chk("busy_after", int'(busy), 0);
    // a few idle cycles: nothing relaunches from a dropped start
    n_ld = 0;
    repeat (3) begin
      @(negedge clk);
      if (ld_regs || busy) n_ld++;
    end
    chk("idle_quiet", n_ld, 0);
  endtask

  initial begin
    mcand = '0; mplier = '0;
    m_reg = '0; q_reg = '0; a_reg = '0; c_reg = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", int'({ld_regs, add_en, shift_en, busy, done}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_mul(4'd7, 4'd0, 1'b0);
    run_mul(4'd5, 4'b1011, 1'b0);
    run_mul(4'd5, 4'b1011, 1'b1);
    run_mul(4'd15, 4'd15, 1'b1);
    for (int i = 0; i < 16; i++)
      run_mul(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // back-to-back with start held high: done, one IDLE cycle, then LOAD
    begin
      int dc = 0, got_idle = 0, got_ld = 0;
      @(negedge clk);
      mcand = 4'd3; mplier = 4'b0110; start = 1'b1;
      for (int cyc = 1; cyc <= 60 && dc < 2; cyc++) begin
        @(negedge clk);
        if (done) begin
          dc++;
          chk("b2b_product", int'({a_reg, q_reg}), 18);
          if (dc == 1) begin
            @(negedge clk); got_idle = int'(!busy);
            @(negedge clk); got_ld = int'(ld_regs);
          end
        end
      end
      start = 1'b0;
      chk("b2b_dones", dc, 2);
      chk("b2b_idle", got_idle, 1);
      chk("b2b_reload", got_ld, 1);
      repeat (20) @(negedge clk);
    end

    // asynchronous reset in the middle of an ADD (or EVAL add)
    begin
      int seen = 0;
      @(negedge clk);
      mcand = 4'd9; mplier = 4'b0001; start = 1'b1;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        if (add_en) seen = 1;
      end
      chk("reached_add", seen, 1);
      #1 rst_n = 1'b0;
      #1 chk("async_rst_outs", int'({ld_regs, add_en, shift_en, busy, done}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      run_mul(4'd9, 4'd13, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
